// File: rtl/writeback_regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module      : writeback_regfile_pkg
// Description : Shared MIPS pipeline definitions. Holds the register file
//               geometry defaults, the zero-register index and the
//               result-select encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package writeback_regfile_pkg;

    localparam int C_DATA_WIDTH  = 32;
    localparam int C_ADDR_WIDTH  = 5;
    localparam int C_ZERO_REG    = 0;
    localparam int C_COUNT_WIDTH = 32;

    typedef enum logic {
        RES_ALU = 1'b0,
        RES_MEM = 1'b1
    } result_sel_e;

endpackage : writeback_regfile_pkg
`default_nettype wire

// File: rtl/regfile_array.sv
`default_nettype none
// ============================================================================
// Module      : regfile_array
// Description : Register storage with one synchronous write port and two
//               combinational read ports. Index 0 is hard-wired to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_array
    import writeback_regfile_pkg::*;
#(
    parameter int DATA_WIDTH = C_DATA_WIDTH,
    parameter int ADDR_WIDTH = C_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [ADDR_WIDTH-1:0] i_raddr1,
    input  logic [ADDR_WIDTH-1:0] i_raddr2,
    output logic [DATA_WIDTH-1:0] o_rdata1,
    output logic [DATA_WIDTH-1:0] o_rdata2
);

    localparam int                  c_NUM_REGS = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] c_ZERO_IDX = ADDR_WIDTH'(C_ZERO_REG);

    logic [DATA_WIDTH-1:0] r_mem [c_NUM_REGS];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < c_NUM_REGS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we && (i_waddr != c_ZERO_IDX)) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Entry 0 is masked on read so it is zero even before the first reset.
    assign o_rdata1 = (i_raddr1 == c_ZERO_IDX) ? '0 : r_mem[i_raddr1];
    assign o_rdata2 = (i_raddr2 == c_ZERO_IDX) ? '0 : r_mem[i_raddr2];

endmodule : regfile_array
`default_nettype wire

// File: rtl/writeback_regfile.sv
`default_nettype none
// ============================================================================
// Module      : writeback_regfile
// Description : MIPS writeback stage: result mux, register file and
//               committed-write counter. Optional macro REGFILE_BYPASS_EN
//               enables same-cycle write-before-read forwarding.
// Revision    : 1.0 - initial release
// ============================================================================
module writeback_regfile
    import writeback_regfile_pkg::*;
#(
    parameter int DATA_WIDTH = C_DATA_WIDTH,
    parameter int ADDR_WIDTH = C_ADDR_WIDTH
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     RegWriteW,
    input  logic                     MemtoRegW,
    input  logic [DATA_WIDTH-1:0]    ReadDataW,
    input  logic [DATA_WIDTH-1:0]    ALUOutW,
    input  logic [ADDR_WIDTH-1:0]    WriteRegW,
    input  logic [ADDR_WIDTH-1:0]    A1,
    input  logic [ADDR_WIDTH-1:0]    A2,
    output logic [DATA_WIDTH-1:0]    RD1,
    output logic [DATA_WIDTH-1:0]    RD2,
    output logic [DATA_WIDTH-1:0]    ResultW,
    output logic [C_COUNT_WIDTH-1:0] WriteCount
);

    localparam logic [ADDR_WIDTH-1:0] c_ZERO_IDX = ADDR_WIDTH'(C_ZERO_REG);

    result_sel_e               w_sel;
    logic [DATA_WIDTH-1:0]     w_result;
    logic                      w_commit;
    logic [DATA_WIDTH-1:0]     w_raw1;
    logic [DATA_WIDTH-1:0]     w_raw2;
    logic [C_COUNT_WIDTH-1:0]  r_write_count;

    assign w_sel    = result_sel_e'(MemtoRegW);
    assign w_result = (w_sel == RES_MEM) ? ReadDataW : ALUOutW;
    assign ResultW  = w_result;

    assign w_commit = RegWriteW && (WriteRegW != c_ZERO_IDX);

    regfile_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_regfile_array (
        .clk      (clock),
        .rst_n    (reset_n),
        .i_we     (RegWriteW),
        .i_waddr  (WriteRegW),
        .i_wdata  (w_result),
        .i_raddr1 (A1),
        .i_raddr2 (A2),
        .o_rdata1 (w_raw1),
        .o_rdata2 (w_raw2)
    );

`ifdef REGFILE_BYPASS_EN
    logic w_byp1;
    logic w_byp2;

    // Forward the in-flight result so decode sees it in the write cycle.
    assign w_byp1 = reset_n && w_commit && (A1 == WriteRegW);
    assign w_byp2 = reset_n && w_commit && (A2 == WriteRegW);
    assign RD1    = w_byp1 ? w_result : w_raw1;
    assign RD2    = w_byp2 ? w_result : w_raw2;
`else
    assign RD1    = w_raw1;
    assign RD2    = w_raw2;
`endif

    // Wraps silently; writes aimed at register 0 are not counted.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_write_count <= '0;
        end else if (w_commit) begin
            r_write_count <= r_write_count + C_COUNT_WIDTH'(1);
        end
    end

    assign WriteCount = r_write_count;

endmodule : writeback_regfile
`default_nettype wire

// File: tb/tb_writeback_regfile.sv
`default_nettype none
// ============================================================================
// Module      : tb_writeback_regfile
// Description : Directed self-checking bench for writeback_regfile.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_writeback_regfile;

    logic        clock;
    logic        reset_n;
    logic        RegWriteW;
    logic        MemtoRegW;
    logic [31:0] ReadDataW;
    logic [31:0] ALUOutW;
    logic [4:0]  WriteRegW;
    logic [4:0]  A1;
    logic [4:0]  A2;
    logic [31:0] RD1;
    logic [31:0] RD2;
    logic [31:0] ResultW;
    logic [31:0] WriteCount;

    int errors = 0;
    int checks = 0;

    writeback_regfile dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .RegWriteW  (RegWriteW),
        .MemtoRegW  (MemtoRegW),
        .ReadDataW  (ReadDataW),
        .ALUOutW    (ALUOutW),
        .WriteRegW  (WriteRegW),
        .A1         (A1),
        .A2         (A2),
        .RD1        (RD1),
        .RD2        (RD2),
        .ResultW    (ResultW),
        .WriteCount (WriteCount)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Inputs change just after the falling edge; outputs are sampled 1ns later.
    task automatic next_cycle();
        @(negedge clock);
    endtask

    task automatic drive_write(input logic we, input logic m2r, input logic [4:0] wr,
                               input logic [31:0] alu, input logic [31:0] rdat);
        RegWriteW = we;
        MemtoRegW = m2r;
        WriteRegW = wr;
        ALUOutW   = alu;
        ReadDataW = rdat;
    endtask

    initial begin
        reset_n = 1'b0;
        drive_write(1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
        A1 = 5'd0;
        A2 = 5'd0;
        repeat (2) @(posedge clock);
        next_cycle();
        reset_n = 1'b1;

        // First cycle after reset: everything reads zero.
        A1 = 5'd5; A2 = 5'd31;
        #1;
        check("reset_rd1_r5",   RD1, 32'h0);
        check("reset_rd2_r31",  RD2, 32'h0);
        check("reset_count",    WriteCount, 32'h0);

        // ALU result into r5.
        drive_write(1'b1, 1'b0, 5'd5, 32'hDEADBEEF, 32'h0);
        #1;
        check("alu_resultw", ResultW, 32'hDEADBEEF);
        next_cycle();
        drive_write(1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
        A1 = 5'd5;
        #1;
        check("r5_readback", RD1, 32'hDEADBEEF);
        check("count_after_r5", WriteCount, 32'd1);

        // Write aimed at r0 is dropped and not counted.
        drive_write(1'b1, 1'b0, 5'd0, 32'h1234, 32'h0);
        A1 = 5'd0;
        #1;
        check("r0_same_cycle", RD1, 32'h0);
        next_cycle();
        drive_write(1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
        #1;
        check("r0_after_write", RD1, 32'h0);
        check("count_r0_write", WriteCount, 32'd1);

        // Load data selected into r31.
        drive_write(1'b1, 1'b1, 5'd31, 32'h1, 32'hA5A5A5A5);
        #1;
        check("mem_resultw", ResultW, 32'hA5A5A5A5);
        next_cycle();
        drive_write(1'b0, 1'b0, 5'd9, 32'h5555, 32'h0);
        A2 = 5'd31;
        #1;
        check("r31_readback", RD2, 32'hA5A5A5A5);
        check("count_after_r31", WriteCount, 32'd2);

        // RegWriteW low: r9 stays clear.
        next_cycle();
        A1 = 5'd9;
        #1;
        check("r9_no_write", RD1, 32'h0);
        check("count_no_write", WriteCount, 32'd2);

        // Same-cycle read of r7 while it is written.
        drive_write(1'b1, 1'b0, 5'd7, 32'h11, 32'h0);
        next_cycle();
        drive_write(1'b1, 1'b0, 5'd7, 32'h77, 32'h0);
        A1 = 5'd7; A2 = 5'd7;
        #1;
`ifdef REGFILE_BYPASS_EN
        check("r7_same_rd1", RD1, 32'h77);
        check("r7_same_rd2", RD2, 32'h77);
`else
        check("r7_same_rd1", RD1, 32'h11);
        check("r7_same_rd2", RD2, 32'h11);
`endif
        next_cycle();
        drive_write(1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
        #1;
        check("r7_next_rd1", RD1, 32'h77);
        check("r7_next_rd2", RD2, 32'h77);
        check("count_after_r7", WriteCount, 32'd4);

        // Reset mid-stream with a pending write to r3.
        drive_write(1'b1, 1'b0, 5'd3, 32'h33, 32'h0);
        next_cycle();
        reset_n = 1'b0;
        drive_write(1'b1, 1'b0, 5'd3, 32'h99, 32'h0);
        A1 = 5'd3; A2 = 5'd31;
        #1;
        check("r3_before_reset", RD1, 32'h33);
        check("count_before_reset", WriteCount, 32'd5);
        next_cycle();
        reset_n = 1'b1;
        drive_write(1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
        #1;
        check("r3_after_reset", RD1, 32'h0);
        check("r31_after_reset", RD2, 32'h0);
        check("count_after_reset", WriteCount, 32'd0);

        // Counter wrap via backdoor preload.
        force dut.r_write_count = 32'hFFFFFFFF;
        #1;
        release dut.r_write_count;
        drive_write(1'b1, 1'b0, 5'd10, 32'hAB, 32'h0);
        next_cycle();
        drive_write(1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
        A1 = 5'd10;
        #1;
        check("count_wrap", WriteCount, 32'd0);
        check("r10_readback", RD1, 32'hAB);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_writeback_regfile
`default_nettype wire
